// File: rtl/wptr_full_level.sv
// Write-domain pointer, full/almost-full/programmable-full flags, fill level and
// sticky overflow for the dual-clock Gray-pointer asynchronous FIFO.
module wptr_full_level #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned PROG_FULL = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                woverflow_clr,
  output logic                wfull,
  output logic                awfull,
  output logic                wprog_full,
  output logic                woverflow,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wclken,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr
);

  localparam logic [ADDRSIZE:0] PROG_FULL_W = (ADDRSIZE+1)'(PROG_FULL);
  localparam logic [ADDRSIZE:0] ONE         = {{ADDRSIZE{1'b0}}, 1'b1};

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wbinnext1;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] wgraynext1;
  logic [ADDRSIZE:0] fullcmp;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;

  assign wclken     = winc & ~wfull;
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wclken};
  assign wbinnext1  = wbinnext + ONE;
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign wgraynext1 = (wbinnext1 >> 1) ^ wbinnext1;

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign fullcmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  assign level_next = wbinnext - rbin_s;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin       <= '0;
      wptr       <= '0;
      wfull      <= 1'b0;
      awfull     <= 1'b0;
      wprog_full <= 1'b0;
      wlevel     <= '0;
      woverflow  <= 1'b0;
    end else begin
      wbin       <= wbinnext;
      wptr       <= wgraynext;
      wfull      <= (wgraynext == fullcmp);
      awfull     <= (wgraynext1 == fullcmp);
      wlevel     <= level_next;
      wprog_full <= (level_next >= PROG_FULL_W);
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (woverflow_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full_level.sv
// Bench for wptr_full_level: directed plan plus random traffic, checked against an
// occupancy-count model of the FIFO write side.
module tb_wptr_full_level;

  localparam int unsigned AS    = 4;
  localparam int          DEPTH = 16;
  localparam int          PF    = 12;

  logic          wclk;
  logic          wrst_n;
  logic          winc;
  logic [AS:0]   wq2_rptr;
  logic          woverflow_clr;
  logic          wfull;
  logic          awfull;
  logic          wprog_full;
  logic          woverflow;
  logic [AS:0]   wlevel;
  logic          wclken;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;

  wptr_full_level #(.ADDRSIZE(AS), .PROG_FULL(PF)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .winc          (winc),
    .wq2_rptr      (wq2_rptr),
    .woverflow_clr (woverflow_clr),
    .wfull         (wfull),
    .awfull        (awfull),
    .wprog_full    (wprog_full),
    .woverflow     (woverflow),
    .wlevel        (wlevel),
    .wclken        (wclken),
    .waddr         (waddr),
    .wptr          (wptr)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Model: total accepted writes, total reads visible to the write side.
  int wr_cnt;
  int rd_cnt;
  bit m_full;
  bit m_ovf;
  int checks;
  int errors;

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    int level;
    level = wr_cnt - rd_cnt;
    check("wlevel",     32'(wlevel),     32'(level));
    check("wfull",      32'(wfull),      32'(level == DEPTH));
    check("awfull",     32'(awfull),     32'(level == DEPTH - 1));
    check("wprog_full", 32'(wprog_full), 32'(level >= PF));
    check("woverflow",  32'(woverflow),  32'(m_ovf));
    check("wptr",       32'(wptr),       32'(gray5(wr_cnt)));
    check("waddr",      32'(waddr),      32'(wr_cnt % DEPTH));
  endtask

  task automatic step(input bit w, input bit rd, input bit clr);
    winc          = w;
    woverflow_clr = clr;
    if (rd && rd_cnt < wr_cnt) rd_cnt++;
    wq2_rptr = gray5(rd_cnt);
    #1;
    check("wclken", 32'(wclken), 32'(w && !m_full));
    @(posedge wclk);
    if (w && !m_full) wr_cnt++;
    if (w && m_full) m_ovf = 1'b1;
    else if (clr)    m_ovf = 1'b0;
    m_full = (wr_cnt - rd_cnt) == DEPTH;
    #1;
    check_regs();
  endtask

  initial begin
    checks = 0; errors = 0;
    wr_cnt = 0; rd_cnt = 0; m_full = 1'b0; m_ovf = 1'b0;
    wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; woverflow_clr = 1'b0;
    #12;
    check_regs();
    check("rst_wclken", 32'(wclken), 32'(0));
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill from empty.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    check("fill_wptr",   32'(wptr),   32'h18);
    check("fill_wlevel", 32'(wlevel), 32'd16);
    check("fill_wfull",  32'(wfull),  32'd1);

    // Writes while full are dropped and flagged.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("ovf_wptr", 32'(wptr),      32'h18);
    check("ovf_set",  32'(woverflow), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("ovf_clr",  32'(woverflow), 32'd0);

    // One read arrives, then one write refills.
    step(1'b0, 1'b1, 1'b0);
    check("rd1_awfull", 32'(awfull), 32'd1);
    check("rd1_wlevel", 32'(wlevel), 32'd15);
    step(1'b1, 1'b0, 1'b0);
    check("refill_wfull", 32'(wfull), 32'd1);

    // Drain to 3, then run steady traffic across the pointer wrap.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    check("wrap_wlevel", 32'(wlevel), 32'd3);

    // Level 15 with simultaneous write and read.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("simul_awfull", 32'(awfull), 32'd1);
    check("simul_wfull",  32'(wfull),  32'd0);

    // Reach level 9 with overflow set, then reset between edges.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    check("pre_rst_wlevel", 32'(wlevel),    32'd9);
    check("pre_rst_ovf",    32'(woverflow), 32'd1);
    #2;
    wrst_n = 1'b0;
    #1;
    wr_cnt = 0; rd_cnt = 0; m_full = 1'b0; m_ovf = 1'b0;
    check_regs();
    check("rst_async_wclken", 32'(wclken), 32'(winc));
    wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;

    // Random traffic: a filling phase then a draining phase.
    for (int i = 0; i < 500; i++) begin
      if (i < 250) step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40, $urandom_range(0, 9) == 0);
      else         step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
